// File: rtl/ula_pkg.sv
// Shared types and constants for the 8-bit ALU and its multi-byte sequencer.
// Function selects follow the 74181 encoding with an active-high carry.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } ula_state_t;

  localparam logic [3:0] S_A_PLUS_CIN = 4'b0000;
  localparam logic [3:0] S_A_PLUS_B   = 4'b1001;
  localparam logic [3:0] S_A_PLUS_A   = 4'b1100;
  localparam logic [3:0] S_A_MINUS_B  = 4'b0110;
  localparam logic [3:0] S_MINUS_ONE  = 4'b0011;
  localparam logic [3:0] S_A_MINUS_1  = 4'b1111;

  localparam logic [3:0] S_NOT_A      = 4'b0000;
  localparam logic [3:0] S_XOR        = 4'b0110;
  localparam logic [3:0] S_XNOR       = 4'b1001;
  localparam logic [3:0] S_AND        = 4'b1011;
  localparam logic [3:0] S_OR         = 4'b1110;
  localparam logic [3:0] S_PASS_A     = 4'b1111;

  localparam logic M_ARIT  = 1'b0;
  localparam logic M_LOGIC = 1'b1;

  function automatic logic [7:0] ula_logic(
    input logic [3:0] s,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    r = '0;
    case (s)
      4'b0000: r = ~a;
      4'b0001: r = ~(a | b);
      4'b0010: r = ~a & b;
      4'b0011: r = 8'h00;
      4'b0100: r = ~(a & b);
      4'b0101: r = ~b;
      4'b0110: r = a ^ b;
      4'b0111: r = a & ~b;
      4'b1000: r = ~a | b;
      4'b1001: r = ~(a ^ b);
      4'b1010: r = b;
      4'b1011: r = a & b;
      4'b1100: r = 8'hFF;
      4'b1101: r = a | ~b;
      4'b1110: r = a | b;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ula_8bits.sv
// 8-bit 74181-style ALU slice: 16 logic and 16 arithmetic functions.
// Carry in/out are active-high; a_eq_b flags an all-ones result.
module ula_8bits
  import ula_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b
);

  logic [7:0] x;
  logic [7:0] y;
  logic [8:0] sum;

  // Every arithmetic function is x + y + c_in; "minus one" adds 0xFF
  always_comb begin
    x = a;
    y = '0;
    case (s)
      4'b0000: begin x = a;        y = 8'h00;  end
      4'b0001: begin x = a | b;    y = 8'h00;  end
      4'b0010: begin x = a | ~b;   y = 8'h00;  end
      4'b0011: begin x = 8'hFF;    y = 8'h00;  end
      4'b0100: begin x = a;        y = a & ~b; end
      4'b0101: begin x = a | b;    y = a & ~b; end
      4'b0110: begin x = a;        y = ~b;     end
      4'b0111: begin x = a & ~b;   y = 8'hFF;  end
      4'b1000: begin x = a;        y = a & b;  end
      4'b1001: begin x = a;        y = b;      end
      4'b1010: begin x = a | ~b;   y = a & b;  end
      4'b1011: begin x = a & b;    y = 8'hFF;  end
      4'b1100: begin x = a;        y = a;      end
      4'b1101: begin x = a | b;    y = a;      end
      4'b1110: begin x = a | ~b;   y = a;      end
      default: begin x = a;        y = 8'hFF;  end
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {8'd0, c_in};

  assign f      = (m == M_LOGIC) ? ula_logic(s, a, b) : sum[7:0];
  assign c_out  = (m == M_ARIT) & sum[8];
  assign a_eq_b = &f;

endmodule

// File: rtl/ula_chain_ctrl.sv
// Runs one wide ALU operation through a single ula_8bits, one byte per
// cycle LSB first, chaining raw carry and returning the result on valid/ready.
module ula_chain_ctrl
  import ula_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [8*N_BYTES-1:0] req_a,
  input  logic [8*N_BYTES-1:0] req_b,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*N_BYTES-1:0] rsp_f,
  output logic                 rsp_cout,
  output logic                 rsp_eq,
  output logic                 busy
);

  localparam int W  = 8 * N_BYTES;
  localparam int IW = $clog2(N_BYTES);

  ula_state_t state, state_nxt;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [3:0]    s_q;
  logic          m_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic          eq_acc;
  logic [W-1:0]  result;

  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [7:0]    alu_f;
  logic          alu_cout;
  logic          alu_eq;
  logic          last;
  logic          accept;

  assign alu_a  = a_q[{idx, 3'b000} +: 8];
  assign alu_b  = b_q[{idx, 3'b000} +: 8];
  assign last   = (idx == IW'(N_BYTES - 1));
  assign accept = (state == IDLE) & req_valid;

  ula_8bits u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .s      (s_q),
    .m      (m_q),
    .c_in   (carry),
    .f      (alu_f),
    .c_out  (alu_cout),
    .a_eq_b (alu_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE: if (req_valid) state_nxt = EXEC;
      state == EXEC: if (last)      state_nxt = DONE;
      state == DONE: if (rsp_ready) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      m_q    <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      eq_acc <= 1'b0;
      result <= '0;
    end else if (accept) begin
      a_q    <= req_a;
      b_q    <= req_b;
      s_q    <= req_s;
      m_q    <= req_m;
      idx    <= '0;
      carry  <= req_cin;
      eq_acc <= 1'b1;
      result <= '0;
    end else if (state == EXEC) begin
      result[{idx, 3'b000} +: 8] <= alu_f;
      carry  <= alu_cout;
      eq_acc <= eq_acc & alu_eq;
      idx    <= last ? '0 : idx + 1'b1;
    end
  end

  // Flags are only meaningful once every slice has been folded in
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_f     = result;
  assign rsp_cout  = rsp_valid & carry & ~m_q;
  assign rsp_eq    = rsp_valid & eq_acc;

endmodule

// File: tb/tb_ula_chain_ctrl.sv
// Directed bench for ula_chain_ctrl with N_BYTES=4.
// Vector table plus backpressure, early-ready and async reset sequences.
module tb_ula_chain_ctrl;
  import ula_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_s;
  logic        req_m;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_f;
  logic        rsp_cout;
  logic        rsp_eq;
  logic        busy;

  int n_chk;
  int n_fail;

  ula_chain_ctrl #(.N_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_s     (req_s),
    .req_m     (req_m),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_cout  (rsp_cout),
    .rsp_eq    (rsp_eq),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic [31:0] f;
    logic        cout;
    logic        chk_eq;
    logic        eq;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic m,
                       input logic cin);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_a     = a;
    req_b     = b;
    req_s     = s;
    req_m     = m;
    req_cin   = cin;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic handshake(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_s     = '0;
    req_m     = 1'b0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;

    vecs[0] = '{"add_nc", 32'h000000FF, 32'h00000001, S_A_PLUS_B,
                M_ARIT, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"add_rip", 32'hFFFFFFFF, 32'h00000001, S_A_PLUS_B,
                M_ARIT, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"a_cin", 32'h12345678, 32'h00000000, S_A_PLUS_CIN,
                M_ARIT, 1'b1, 32'h12345679, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"a_cin_wrap", 32'hFFFFFFFF, 32'h00000000, S_A_PLUS_CIN,
                M_ARIT, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"xor", 32'h5A5A5A5A, 32'h33333333, S_XOR,
                M_LOGIC, 1'b0, 32'h69696969, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"not_a", 32'h5A5A5A5A, 32'h33333333, S_NOT_A,
                M_LOGIC, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"a_plus_a", 32'h80000001, 32'h00000000, S_A_PLUS_A,
                M_ARIT, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"and", 32'hF0F0FFFF, 32'h0FF0F00F, S_AND,
                M_LOGIC, 1'b0, 32'h00F0F00F, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"sub_eq", 32'h12345678, 32'h12345678, S_A_MINUS_B,
                M_ARIT, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{"sub_ne", 32'h12345678, 32'h12335678, S_A_MINUS_B,
                M_ARIT, 1'b0, 32'h0000FFFF, 1'b1, 1'b1, 1'b0};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_f", 64'(rsp_f), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_rsp_eq", 64'(rsp_eq), 64'd0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin);
      chk({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
      chk({vecs[i].name, "_ready_low"}, 64'(req_ready), 64'd0);
      wait_rsp(vecs[i].name);
      chk({vecs[i].name, "_f"}, 64'(rsp_f), 64'(vecs[i].f));
      chk({vecs[i].name, "_cout"}, 64'(rsp_cout), 64'(vecs[i].cout));
      if (vecs[i].chk_eq)
        chk({vecs[i].name, "_eq"}, 64'(rsp_eq), 64'(vecs[i].eq));
      handshake(vecs[i].name);
    end

    // Backpressure with a stray request while the response is held
    issue(32'h11111111, 32'h22222222, S_A_PLUS_B, M_ARIT, 1'b0);
    wait_rsp("bp");
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_held", 64'(rsp_valid), 64'd1);
      chk("bp_f_held", 64'(rsp_f), 64'h33333333);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      if (i == 1) begin
        req_a     = 32'hDEADBEEF;
        req_b     = 32'h01010101;
        req_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    chk("bp_f_final", 64'(rsp_f), 64'h33333333);
    handshake("bp");
    for (int i = 0; i < 6; i++) begin
      chk("bp_no_second", 64'(busy | rsp_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // rsp_ready already high: handshake on first valid cycle
    rsp_ready = 1'b1;
    issue(32'h0000FFFF, 32'h00000001, S_A_PLUS_B, M_ARIT, 1'b0);
    wait_rsp("early");
    chk("early_f", 64'(rsp_f), 64'h00010000);
    @(posedge clk);
    #1;
    chk("early_valid_drop", 64'(rsp_valid), 64'd0);
    chk("early_ready_back", 64'(req_ready), 64'd1);
    rsp_ready = 1'b0;

    // Asynchronous reset after two slices
    issue(32'h01010101, 32'h01010101, S_A_PLUS_B, M_ARIT, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_partial_f", 64'(rsp_f), 64'h00000202);
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_f", 64'(rsp_f), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    issue(32'h00010001, 32'h00010001, S_A_PLUS_B, M_ARIT, 1'b0);
    wait_rsp("post_rst");
    chk("post_rst_f", 64'(rsp_f), 64'h00020002);
    chk("post_rst_cout", 64'(rsp_cout), 64'd0);
    handshake("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
